// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - range-checks a 32-bit immediate and scatters it into the RISC-V inm[24:0] field
// Two-stage valid/ready pipeline: stage 1 captures and range-checks, stage 2 packs and holds the result.
module imm_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_imm,
  input  logic [2:0]       in_type,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      out_inm,
  output logic [24:0]      out_mask,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] TYPE_I = 3'b000;
  localparam logic [2:0] TYPE_S = 3'b001;
  localparam logic [2:0] TYPE_B = 3'b010;
  localparam logic [2:0] TYPE_U = 3'b011;
  localparam logic [2:0] TYPE_J = 3'b100;

  localparam logic [24:0] MASK_I  = 25'h1FFE000;
  localparam logic [24:0] MASK_SB = 25'h1FC001F;
  localparam logic [24:0] MASK_UJ = 25'h1FFFFE0;

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_imm_q,   s1_imm_d;
  logic [2:0]       s1_type_q,  s1_type_d;
  logic             s1_err_q,   s1_err_d;
  logic             s2_valid_q, s2_valid_d;
  logic [24:0]      inm_q,      inm_d;
  logic [24:0]      mask_q,     mask_d;
  logic             err_q,      err_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic        s1_adv;
  logic        in_fire;
  logic        in_err;
  logic [24:0] pack_inm;
  logic [24:0] pack_mask;

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;

  // A signed N-bit immediate fits when all bits from N-1 upward agree.
  always_comb begin
    in_err = 1'b1;
    case (in_type)
      TYPE_I, TYPE_S: in_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      TYPE_B:         in_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      TYPE_U:         in_err = |in_imm[11:0];
      TYPE_J:         in_err = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      default:        in_err = 1'b1;
    endcase
  end

  always_comb begin
    pack_inm  = '0;
    pack_mask = '0;
    case (s1_type_q)
      TYPE_I: begin
        pack_inm[24:13] = s1_imm_q[11:0];
        pack_mask       = MASK_I;
      end
      TYPE_S: begin
        pack_inm[24:18] = s1_imm_q[11:5];
        pack_inm[4:0]   = s1_imm_q[4:0];
        pack_mask       = MASK_SB;
      end
      TYPE_B: begin
        pack_inm[24]    = s1_imm_q[12];
        pack_inm[23:18] = s1_imm_q[10:5];
        pack_inm[4:1]   = s1_imm_q[4:1];
        pack_inm[0]     = s1_imm_q[11];
        pack_mask       = MASK_SB;
      end
      TYPE_U: begin
        pack_inm[24:5]  = s1_imm_q[31:12];
        pack_mask       = MASK_UJ;
      end
      TYPE_J: begin
        pack_inm[24]    = s1_imm_q[20];
        pack_inm[23:14] = s1_imm_q[10:1];
        pack_inm[13]    = s1_imm_q[11];
        pack_inm[12:5]  = s1_imm_q[19:12];
        pack_mask       = MASK_UJ;
      end
      default: begin
        pack_inm  = '0;
        pack_mask = '0;
      end
    endcase
    if (s1_err_q) begin
      pack_inm  = '0;
      pack_mask = '0;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_imm_d   = s1_imm_q;
    s1_type_d  = s1_type_q;
    s1_err_d   = s1_err_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_imm_d   = in_imm;
      s1_type_d  = in_type;
      s1_err_d   = in_err;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 only reloads when it can advance, so held results stay stable under backpressure.
  always_comb begin
    s2_valid_d = s2_valid_q;
    inm_d      = inm_q;
    mask_d     = mask_q;
    err_d      = err_q;
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        inm_d  = pack_inm;
        mask_d = pack_mask;
        err_d  = s1_err_q;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (s2_valid_q && out_ready && err_q && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_imm_q   <= '0;
      s1_type_q  <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      inm_q      <= '0;
      mask_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_imm_q   <= s1_imm_d;
      s1_type_q  <= s1_type_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      inm_q      <= inm_d;
      mask_q     <= mask_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_inm   = inm_q;
  assign out_mask  = mask_q;
  assign out_err   = err_q;
  assign err_count = cnt_q;

endmodule
